zbus_arb: RTL and testbench

Arbiter that shares one zbus point-to-point output channel (vld/aen/den/adr/dat/rdy) among N requesting zbus p2p input channels. The block sits between several masters' write (or read) ports and a single slave p2p input port. It grants exactly one requester at a time and holds the grant until that requester's transfer completes, so the address/data stability rule is never broken. Selection is round-robin by default, or fixed priority when configured.

---
 rtl/zbus_pkg.sv | 24 ++
 rtl/zbus_arb_pick.sv | 53 +++++
 rtl/zbus_arb.sv | 112 +++++++++++
 tb/tb_zbus_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbus_pkg.sv
// zbus_pkg: shared state type, default bus widths and a one-hot decode helper
// used by the zbus arbiter and its picker.
package zbus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ZBUS_WA_DEF = 32;
  localparam int ZBUS_WD_DEF = 32;
  localparam int ZBUS_N_MAX  = 16;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic logic [3:0] onehot_to_idx(input logic [ZBUS_N_MAX-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < ZBUS_N_MAX; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/zbus_arb_pick.sv
// zbus_arb_pick: combinational N-way winner selection for the zbus arbiter.
// Round-robin starting after ptr by default; with ZBUS_ARB_PRIO_EN defined
// the lowest requesting index always wins and ptr is ignored.
module zbus_arb_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win
);

`ifdef ZBUS_ARB_PRIO_EN

  logic found;
  logic ptr_unused;

  assign ptr_unused = ^ptr;

  // Lowest set request bit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

`else

  logic          found;
  logic [IW-1:0] idx;

  // Scan ptr+1 .. ptr+N (mod N); the first set request bit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/zbus_arb.sv
// zbus_arb: shares one zbus p2p output channel among N requesters. A grant is
// registered one cycle after a request is seen and held until the transfer
// completes (or the granted requester drops valid), followed by one IDLE cycle.
// Build option: define ZBUS_ARB_PRIO_EN for fixed priority instead of round-robin.
module zbus_arb
  import zbus_pkg::*;
#(
  parameter int N  = 4,
  parameter int WA = ZBUS_WA_DEF,
  parameter int WD = ZBUS_WD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         s_vld,
  input  logic [N-1:0]         s_aen,
  input  logic [N-1:0]         s_den,
  input  logic [N-1:0][WA-1:0] s_adr,
  input  logic [N-1:0][WD-1:0] s_dat,
  output logic [N-1:0]         s_rdy,
  output logic                 m_vld,
  output logic                 m_aen,
  output logic                 m_den,
  output logic [WA-1:0]        m_adr,
  output logic [WD-1:0]        m_dat,
  input  logic                 m_rdy,
  output logic [N-1:0]         gnt,
  output logic                 busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    state;
  logic [N-1:0]  win;
  logic [IW-1:0] ptr;
  logic          trn;

`ifdef ZBUS_ARB_PRIO_EN
  assign ptr = '0;
`else
  logic [ZBUS_N_MAX-1:0] win_ext;
  logic [IW-1:0]         win_idx;

  // Widen the winner vector so the package decoder can turn it into an index.
  always_comb begin
    win_ext        = '0;
    win_ext[N-1:0] = win;
  end

  assign win_idx = IW'(onehot_to_idx(win_ext));
`endif

  zbus_arb_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req (s_vld),
    .ptr (ptr),
    .win (win)
  );

  // Grant FSM: latch the winner from IDLE, release on transfer or dropped valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
`ifndef ZBUS_ARB_PRIO_EN
      ptr   <= IW'(N - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|s_vld) begin
            gnt   <= win;
            state <= BUSY;
`ifndef ZBUS_ARB_PRIO_EN
            ptr   <= win_idx;
`endif
          end
        end
        BUSY: begin
          if (trn || !m_vld) begin
            gnt   <= '0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Route the granted requester onto the shared channel; all zero without a grant.
  always_comb begin
    m_vld = 1'b0;
    m_aen = 1'b0;
    m_den = 1'b0;
    m_adr = '0;
    m_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        m_vld = s_vld[i];
        m_aen = s_aen[i];
        m_den = s_den[i];
        m_adr = s_adr[i];
        m_dat = s_dat[i];
      end
    end
  end

  assign trn   = m_vld & m_rdy;
  assign s_rdy = gnt & {N{m_rdy}};
  assign busy  = (state == BUSY);

endmodule

// File: tb/tb_zbus_arb.sv
// tb_zbus_arb: scoreboard bench for zbus_arb. The stimulus process drives one
// cycle at a time, advances a queue/integer reference model of the arbiter and
// pushes the expected outputs; a negedge monitor pops and compares them.
module tb_zbus_arb;

  localparam int N  = 4;
  localparam int WA = 32;
  localparam int WD = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         s_vld, s_aen, s_den, s_rdy, gnt;
  logic [N-1:0][WA-1:0] s_adr;
  logic [N-1:0][WD-1:0] s_dat;
  logic                 m_vld, m_aen, m_den, m_rdy, busy;
  logic [WA-1:0]        m_adr;
  logic [WD-1:0]        m_dat;

  always #5 clk = ~clk;

  zbus_arb #(.N(N), .WA(WA), .WD(WD)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_vld (s_vld),
    .s_aen (s_aen),
    .s_den (s_den),
    .s_adr (s_adr),
    .s_dat (s_dat),
    .s_rdy (s_rdy),
    .m_vld (m_vld),
    .m_aen (m_aen),
    .m_den (m_den),
    .m_adr (m_adr),
    .m_dat (m_dat),
    .m_rdy (m_rdy),
    .gnt   (gnt),
    .busy  (busy)
  );

  typedef struct {
    logic [N-1:0]  gnt;
    logic [N-1:0]  s_rdy;
    logic          busy;
    logic          vld;
    logic          aen;
    logic          den;
    logic [WA-1:0] adr;
    logic [WD-1:0] dat;
    int            tag;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;

  // Reference model: who holds the channel, and who won last.
  int holder = -1;
  int last   = N - 1;

  logic [N-1:0]         rr_log[$];
  int                   trn_cnt = 0;
  logic [N-1:0][WA-1:0] adr_v;
  logic [N-1:0][WD-1:0] dat_v;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      adr_v[i] = $urandom;
      dat_v[i] = $urandom;
    end
  endtask

  // Advance the model across a rising edge, using the inputs of the cycle just ended.
  task automatic advance_model();
    int start;
    int c;
    bit found;
    if (!rst) begin
      holder = -1;
      last   = N - 1;
    end else if (holder < 0) begin
`ifdef ZBUS_ARB_PRIO_EN
      start = N - 1;
`else
      start = last;
`endif
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (start + k) % N;
        if (!found && s_vld[c]) begin
          holder = c;
          last   = c;
          found  = 1;
        end
      end
    end else if (!s_vld[holder] || m_rdy) begin
      holder = -1;
    end
  endtask

  task automatic apply_stimulus(input logic [N-1:0] vld, input logic [N-1:0] aen,
                                input logic [N-1:0] den, input logic rdy,
                                input logic rst_v, input int tag);
    exp_t e;
    advance_model();
    s_vld = vld;
    s_aen = aen;
    s_den = den;
    s_adr = adr_v;
    s_dat = dat_v;
    m_rdy = rdy;
    rst   = rst_v;
    if (!rst) begin
      holder = -1;
      last   = N - 1;
    end
    e.tag = tag;
    if (holder >= 0) begin
      e.gnt   = '0;
      e.gnt[holder] = 1'b1;
      e.s_rdy = rdy ? e.gnt : '0;
      e.busy  = 1'b1;
      e.vld   = vld[holder];
      e.aen   = aen[holder];
      e.den   = den[holder];
      e.adr   = adr_v[holder];
      e.dat   = dat_v[holder];
    end else begin
      e.gnt   = '0;
      e.s_rdy = '0;
      e.busy  = 1'b0;
      e.vld   = 1'b0;
      e.aen   = 1'b0;
      e.den   = 1'b0;
      e.adr   = '0;
      e.dat   = '0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each cycle against the model, plus constant checks for directed phases.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("gnt",   64'(gnt),   64'(e.gnt));
      check_output("busy",  64'(busy),  64'(e.busy));
      check_output("s_rdy", 64'(s_rdy), 64'(e.s_rdy));
      check_output("m_vld", 64'(m_vld), 64'(e.vld));
      check_output("m_aen", 64'(m_aen), 64'(e.aen));
      check_output("m_den", 64'(m_den), 64'(e.den));
      check_output("m_adr", 64'(m_adr), 64'(e.adr));
      check_output("m_dat", 64'(m_dat), 64'(e.dat));
      case (e.tag)
        1: begin
          if (rr_log.size() < 8 && m_vld && m_rdy) trn_cnt++;
          rr_log.push_back(gnt);
        end
        2: begin
          check_output("bp_adr",   64'(m_adr), 64'(32'h1000));
          check_output("bp_gnt",   64'(gnt),   64'(4'b0100));
          check_output("bp_srdy",  64'(s_rdy & 4'b1011), 64'(0));
        end
        3: check_output("drop_busy", 64'(busy), 64'(0));
        4: begin
          check_output("rst_m_vld", 64'(m_vld), 64'(0));
          check_output("rst_gnt",   64'(gnt),   64'(0));
        end
        5: check_output("first_win", 64'(gnt), 64'(4'b0001));
        6: check_output("prio_gnt_ok", 64'(gnt == 4'b0000 || gnt == 4'b0010), 64'(1));
        8: check_output("rearb_gnt", 64'(gnt), 64'(4'b0010));
        default: ;
      endcase
    end
  end

  initial begin
    logic [N-1:0] rr_exp [9];
    logic [N-1:0] v;
    rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001};
    rst   = 1'b0;
    s_vld = '0;
    s_aen = '0;
    s_den = '0;
    s_adr = '0;
    s_dat = '0;
    m_rdy = 1'b0;
    adr_v = '0;
    dat_v = '0;
    @(posedge clk);
    #1;

    $display("[TB] reset with requests pending");
    rand_data();
    for (int i = 0; i < 3; i++) apply_stimulus(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0, 4);

    apply_stimulus(4'b1111, 4'b1010, 4'b0101, 1'b1, 1'b1, 0);
`ifdef ZBUS_ARB_PRIO_EN
    $display("[TB] fixed priority with 1010");
    for (int i = 0; i < 11; i++) begin
      rand_data();
      apply_stimulus(4'b1010, 4'b1111, 4'b0000, 1'b1, 1'b1, 6);
    end
`else
    $display("[TB] round-robin sweep");
    for (int i = 0; i < 9; i++) begin
      rand_data();
      apply_stimulus(4'b1111, 4'($urandom), 4'($urandom), 1'b1, 1'b1, 1);
    end
    check_output("rr_len", 64'(rr_log.size()), 64'(9));
    for (int i = 0; i < 9; i++) begin
      if (i < rr_log.size()) check_output($sformatf("rr_gnt[%0d]", i), 64'(rr_log[i]), 64'(rr_exp[i]));
    end
    check_output("rr_trn_cnt", 64'(trn_cnt), 64'(4));
`endif

    $display("[TB] backpressure on requester 2");
    rand_data();
    adr_v[2] = 32'h1000;
    apply_stimulus(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(4'b1111, 4'b0100, 4'b0000, 1'b0, 1'b1, 2);
    apply_stimulus(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 0);

    $display("[TB] dropped valid");
    rand_data();
    apply_stimulus(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 0);
    apply_stimulus(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 0);
    apply_stimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 0);
    apply_stimulus(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 3);
    apply_stimulus(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 8);

    $display("[TB] reset mid-transfer");
    apply_stimulus(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 4);
    apply_stimulus(4'b1111, 4'b0010, 4'b0000, 1'b0, 1'b0, 4);
    apply_stimulus(4'b1111, 4'b0010, 4'b0000, 1'b0, 1'b1, 0);
    apply_stimulus(4'b1111, 4'b0010, 4'b0000, 1'b1, 1'b1, 5);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      rand_data();
      v = '0;
      for (int b = 0; b < N; b++) v[b] = ($urandom_range(0, 3) != 0);
      apply_stimulus(v, 4'($urandom), 4'($urandom), 1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 63) != 0), 0);
    end
    apply_stimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 0);
    apply_stimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 0);

    repeat (2) @(negedge clk);
    #1;
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
